pix_proc_pipe: RTL
==================

Name: pix_proc_pipe

Overview:
Parametrised successor to the two-pixel ZBT processing stage. Accepts packed multi-pixel words with their ZBT write address and delays both through a configurable-depth circular buffer. It then applies a switch-selected per-pixel operation (pass, LSB mask, threshold, invert) and emits the processed word with its aligned address. It sits between the camera/ZBT read path and the ZBT bank-1 write port. Configuration changes are latched from the button and applied only at frame boundaries, so no frame is torn.

Parameters:
PIX_W, 18, bits per pixel; packed as 3 equal channels R,G,B, MSB first; must be a multiple of 3, CH_W = PIX_W/3 >= 3
NPIX, 2, pixels per data word
DELAY, 80, alignment delay in cycles through the buffer; minimum 2
ADDR_W, 19, ZBT address width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
in_valid  in  1  pix_in/addr_in valid this cycle
pix_in  in  NPIX*PIX_W  packed pixels; pixel 0 in the MSBs
addr_in  in  ADDR_W  ZBT write address for pix_in
frame_start  in  1  single-cycle pulse at the start of a frame
switch_vals  in  3  operation argument
switch_sels  in  2  mode: 00 pass, 01 mask, 10 threshold, 11 invert
change  in  1  raw, asynchronous pushbutton; requests a config update
out_valid  out  1  pix_out/addr_out valid
pix_out  out  NPIX*PIX_W  processed pixels
addr_out  out  ADDR_W  address aligned to pix_out
cfg_pending  out  1  an update is captured and waits for frame_start

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - out_valid, pix_out, addr_out and cfg_pending go to 0.
  - Active config = pass mode, arg 0.
  - All buffer valid tags clear; buffer data contents are don't-care.
- Delay buffer: circular array of DELAY entries {valid, addr, data}.
  - Pointer advances every cycle, wrapping DELAY-1 -> 0.
  - Each cycle the entry at the pointer is read, then overwritten with the current input.
  - It runs whether or not in_valid is high; invalid slots propagate as bubbles.
- Pipeline stages:
  - S1 registers the buffer read.
  - S2 computes the operation and registers the outputs.
  - Total latency in_valid -> out_valid is exactly DELAY+2 cycles.
  - Address and data stay aligned exactly.
  - When an entry is invalid, pix_out and addr_out hold their previous values.
- Per-pixel operation, applied independently to each of the NPIX pixels and each channel:
  - pass: output = input.
  - mask: clear the low s bits of every channel, where s = min(switch_vals_active, CH_W). s=0 means pass.
  - threshold: T = arg << (CH_W-3). Pixel = all ones if R >= T, else all zeros. arg=0 gives all ones.
  - invert: output = bitwise NOT of the pixel.
- Config update path:
  - change goes through a 2-flop synchronizer, then rising-edge detect.
  - On an edge, pending <= {switch_sels, switch_vals} and cfg_pending <= 1.
  - On frame_start with cfg_pending=1: active <= pending, cfg_pending <= 0. The new config affects S2 from the next cycle.
  - If an edge and frame_start coincide, the previously pending value is applied; the new capture becomes pending and cfg_pending stays 1.
  - Holding change high produces no repeated captures.
  - A frame_start with no pending update has no effect.
- Reset during operation: all in-flight data is dropped. out_valid is guaranteed 0 for the first DELAY+2 cycles after release.

Optional Feature:
PIX_PROC_STATS_EN
- Defined:
  - Adds output match_count [ADDR_W+$clog2(NPIX):0].
  - An internal counter adds the number of all-ones output pixels in each valid output word while threshold mode is active.
  - On frame_start: match_count <= counter (plus this cycle's contribution), then the counter clears.
  - Reset clears both.
- Not defined: the port and the logic are absent; all other behaviour is identical.

Decomposition:
- Package pix_proc_pkg holds:
  - mode encoding constants MODE_PASS/MASK/THRESH/INV;
  - the cfg_t typedef {mode[1:0], arg[2:0]};
  - the channel-slicing helper function.
- One natural sub-module: pix_op (combinational, one pixel plus cfg -> one pixel), instantiated NPIX times in a generate loop.

Test Plan:
- Pass mode, DELAY=80: in_valid pulse with pix_in=36'hABCDE1234, addr_in=19'h1F00 -> out_valid exactly 82 cycles later with identical pix_out and addr_out.
- Mask update: switch_sels=01, switch_vals=3, pulse change mid-frame -> cfg_pending=1, output still unmasked. After frame_start, pixel 18'h3FFFF -> 18'h38E38 (each 6-bit channel = 111000), cfg_pending=0.
- Threshold, arg=4 (T=32): R=6'd32 -> pixel 18'h3FFFF; R=6'd31 -> 18'h00000. Both pixels in the word are evaluated independently.
- Continuous in_valid for 500 cycles with incrementing addr_in (covers pointer wrap) -> 500 consecutive outputs, addresses in order with no gaps or duplicates.
- Coincident change edge and frame_start with pending=invert, new=mask -> invert becomes active, mask pending, cfg_pending stays 1. The next frame_start activates mask.
- Reset asserted after 40 valid inputs -> outputs go to 0 immediately; after release, no out_valid for 82 cycles, and mode is back to pass.

Source files
------------

// File: rtl/pix_proc_pkg.sv
// Shared types and helpers for the pixel processing pipeline.
// Holds the mode encoding, the configuration record, and the channel slicer.
package pix_proc_pkg;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'b00,
    MODE_MASK   = 2'b01,
    MODE_THRESH = 2'b10,
    MODE_INV    = 2'b11
  } mode_e;

  typedef struct packed {
    mode_e      mode;
    logic [2:0] arg;
  } cfg_t;

  localparam cfg_t CFG_RESET = '{mode: MODE_PASS, arg: 3'd0};

  // Widest pixel the channel slicer can handle.
  localparam int MAX_PIX_W = 96;

  // Returns channel ch (0 = R, the MSB channel) of a pixel pix_w bits wide, right-aligned.
  function automatic logic [MAX_PIX_W-1:0] ch_get(input logic [MAX_PIX_W-1:0] pix,
                                                  input int pix_w,
                                                  input int ch);
    logic [MAX_PIX_W-1:0] mask;
    int ch_w;
    ch_w = pix_w / 3;
    mask = (MAX_PIX_W'(1) << ch_w) - MAX_PIX_W'(1);
    return (pix >> (pix_w - (ch + 1) * ch_w)) & mask;
  endfunction

endpackage

// File: rtl/pix_proc_pipe_op.sv
// Combinational per-pixel operation: pass, low-bit mask, red-channel threshold, invert.
module pix_op
  import pix_proc_pkg::*;
#(
  parameter int PIX_W = 18
) (
  input  logic [PIX_W-1:0] pix_i,
  input  cfg_t             cfg_i,
  output logic [PIX_W-1:0] pix_o
);

  localparam int CH_W = PIX_W / 3;

  logic [MAX_PIX_W-1:0] pix_ext;
  logic [CH_W-1:0]      r_ch;
  logic [CH_W-1:0]      g_ch;
  logic [CH_W-1:0]      b_ch;
  logic [CH_W-1:0]      keep;
  logic [CH_W-1:0]      thr;
  int                   mask_bits;

  // Split the pixel into channels and apply the operation selected by the active config.
  always_comb begin
    pix_ext   = MAX_PIX_W'(pix_i);
    r_ch      = CH_W'(ch_get(pix_ext, PIX_W, 0));
    g_ch      = CH_W'(ch_get(pix_ext, PIX_W, 1));
    b_ch      = CH_W'(ch_get(pix_ext, PIX_W, 2));
    mask_bits = (int'(cfg_i.arg) > CH_W) ? CH_W : int'(cfg_i.arg);
    keep      = '0;
    for (int i = 0; i < CH_W; i++) begin
      keep[i] = (i >= mask_bits);
    end
    thr   = CH_W'(cfg_i.arg) << (CH_W - 3);
    pix_o = pix_i;
    case (cfg_i.mode)
      MODE_PASS:   pix_o = pix_i;
      MODE_MASK:   pix_o = {r_ch & keep, g_ch & keep, b_ch & keep};
      MODE_THRESH: pix_o = (r_ch >= thr) ? '1 : '0;
      MODE_INV:    pix_o = ~pix_i;
      default:     pix_o = pix_i;
    endcase
  end

endmodule

// File: rtl/pix_proc_pipe.sv
// Pixel processing pipeline: circular delay buffer, S1 read register, S2 operation register.
// Configuration is captured from a debounced-by-sync pushbutton and applied only at frame_start.
// Optional build macro PIX_PROC_STATS_EN adds the match_count threshold-hit statistics port.
module pix_proc_pipe
  import pix_proc_pkg::*;
#(
  parameter int PIX_W  = 18,
  parameter int NPIX   = 2,
  parameter int DELAY  = 80,
  parameter int ADDR_W = 19
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [NPIX*PIX_W-1:0] pix_in,
  input  logic [ADDR_W-1:0]     addr_in,
  input  logic                  frame_start,
  input  logic [2:0]            switch_vals,
  input  logic [1:0]            switch_sels,
  input  logic                  change,
  output logic                  out_valid,
  output logic [NPIX*PIX_W-1:0] pix_out,
  output logic [ADDR_W-1:0]     addr_out,
  output logic                  cfg_pending
`ifdef PIX_PROC_STATS_EN
  ,
  output logic [ADDR_W+$clog2(NPIX):0] match_count
`endif
);

  localparam int WORD_W = NPIX * PIX_W;
  localparam int PTR_W  = $clog2(DELAY);

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [DELAY-1:0]  buf_vld_q, buf_vld_d;
  logic [ADDR_W-1:0] buf_addr_q [DELAY];
  logic [WORD_W-1:0] buf_data_q [DELAY];

  logic              s1_vld_q, s1_vld_d;
  logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
  logic [WORD_W-1:0] s1_data_q, s1_data_d;

  logic              out_valid_q, out_valid_d;
  logic [WORD_W-1:0] pix_out_q, pix_out_d;
  logic [ADDR_W-1:0] addr_out_q, addr_out_d;

  logic change_meta_q, change_sync_q, change_prev_q;
  logic change_rise;
  cfg_t active_q, active_d;
  cfg_t pending_q, pending_d;
  logic cfg_pending_q, cfg_pending_d;

  logic [WORD_W-1:0] op_data;

  // Circular buffer bookkeeping: read the slot at the pointer, overwrite it with this cycle's input.
  always_comb begin
    ptr_d          = (ptr_q == PTR_W'(DELAY - 1)) ? '0 : ptr_q + PTR_W'(1);
    buf_vld_d      = buf_vld_q;
    buf_vld_d[ptr_q] = in_valid;
    s1_vld_d       = buf_vld_q[ptr_q];
    s1_addr_d      = buf_addr_q[ptr_q];
    s1_data_d      = buf_data_q[ptr_q];
  end

  // Buffer payload storage; contents are don't-care after reset because the valid tags gate them.
  always_ff @(posedge clk) begin
    buf_addr_q[ptr_q] <= addr_in;
    buf_data_q[ptr_q] <= pix_in;
  end

  // One operator per pixel; pixel 0 lives in the MSBs of the word.
  for (genvar g = 0; g < NPIX; g++) begin : g_pix
    pix_op #(.PIX_W(PIX_W)) u_op (
      .pix_i (s1_data_q[(NPIX-1-g)*PIX_W +: PIX_W]),
      .cfg_i (active_q),
      .pix_o (op_data[(NPIX-1-g)*PIX_W +: PIX_W])
    );
  end

  // S2 output register: bubbles leave the previous data and address in place.
  always_comb begin
    out_valid_d = s1_vld_q;
    pix_out_d   = pix_out_q;
    addr_out_d  = addr_out_q;
    if (s1_vld_q) begin
      pix_out_d  = op_data;
      addr_out_d = s1_addr_q;
    end
  end

  // Config update: a frame boundary promotes the older pending value before a new capture replaces it.
  always_comb begin
    change_rise   = change_sync_q & ~change_prev_q;
    active_d      = active_q;
    pending_d     = pending_q;
    cfg_pending_d = cfg_pending_q;
    if (frame_start && cfg_pending_q) begin
      active_d      = pending_q;
      cfg_pending_d = 1'b0;
    end
    if (change_rise) begin
      pending_d.mode = mode_e'(switch_sels);
      pending_d.arg  = switch_vals;
      cfg_pending_d  = 1'b1;
    end
  end

  // All pipeline and control state, cleared asynchronously so in-flight words are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q         <= '0;
      buf_vld_q     <= '0;
      s1_vld_q      <= 1'b0;
      s1_addr_q     <= '0;
      s1_data_q     <= '0;
      out_valid_q   <= 1'b0;
      pix_out_q     <= '0;
      addr_out_q    <= '0;
      change_meta_q <= 1'b0;
      change_sync_q <= 1'b0;
      change_prev_q <= 1'b0;
      active_q      <= CFG_RESET;
      pending_q     <= CFG_RESET;
      cfg_pending_q <= 1'b0;
    end else begin
      ptr_q         <= ptr_d;
      buf_vld_q     <= buf_vld_d;
      s1_vld_q      <= s1_vld_d;
      s1_addr_q     <= s1_addr_d;
      s1_data_q     <= s1_data_d;
      out_valid_q   <= out_valid_d;
      pix_out_q     <= pix_out_d;
      addr_out_q    <= addr_out_d;
      change_meta_q <= change;
      change_sync_q <= change_meta_q;
      change_prev_q <= change_sync_q;
      active_q      <= active_d;
      pending_q     <= pending_d;
      cfg_pending_q <= cfg_pending_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign pix_out     = pix_out_q;
  assign addr_out    = addr_out_q;
  assign cfg_pending = cfg_pending_q;

`ifdef PIX_PROC_STATS_EN
  localparam int CNT_W = ADDR_W + $clog2(NPIX) + 1;

  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0] match_count_q, match_count_d;
  logic [CNT_W-1:0] contrib;

  // Count all-ones pixels of each word leaving S2 in threshold mode; publish and clear per frame.
  always_comb begin
    contrib = '0;
    if (s1_vld_q && (active_q.mode == MODE_THRESH)) begin
      for (int p = 0; p < NPIX; p++) begin
        if (&op_data[p*PIX_W +: PIX_W]) begin
          contrib = contrib + CNT_W'(1);
        end
      end
    end
    match_cnt_d   = match_cnt_q + contrib;
    match_count_d = match_count_q;
    if (frame_start) begin
      match_count_d = match_cnt_q + contrib;
      match_cnt_d   = '0;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match_cnt_q   <= '0;
      match_count_q <= '0;
    end else begin
      match_cnt_q   <= match_cnt_d;
      match_count_q <= match_count_d;
    end
  end

  assign match_count = match_count_q;
`endif

endmodule
